// File: rtl/cache_pkg.sv
// Shared types and AHB-Lite encodings for the cache front end.
package cache_pkg;

    typedef logic [1:0] state_t;

    // Responder data-phase state
    localparam state_t IDLE = 2'd0;
    localparam state_t READ = 2'd1;
    localparam state_t ERR1 = 2'd2;
    localparam state_t ERR2 = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'h2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/cache_ahb_ctrl_in.sv
// AHB-Lite responder forwarding word reads to the cache core; anything else
// gets a two-cycle ERROR response and never reaches the core.
module cache_ahb_ctrl_in
    import cache_pkg::*;
(
    input  logic        i_hclk,
    input  logic        i_hnreset,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [2:0]  i_hburst,
    input  logic [3:0]  i_hprot,
    input  logic [3:0]  i_hmaster,
    input  logic [1:0]  i_htrans,
    input  logic        i_hready,
    input  logic [31:0] i_hwdata,
    output logic        o_hreadyout,
    output logic        o_hresp,
    output logic [31:0] o_hrdata,
    output logic        o_sel,
    output logic [29:0] o_addr,
    input  logic [31:0] i_rdata,
    input  logic        i_ready
);

    state_t      state_q, state_d;
    logic [29:0] addr_q;
    logic        accept;
    logic        bad;
    logic        phase_done;
    logic        unused_inputs;

    assign accept = i_hsel & i_htrans[1] & i_hready;
    assign bad    = i_hwrite | (i_hsize != HSIZE_WORD) | (i_haddr[1:0] != 2'b00);

    assign unused_inputs = ^{i_hburst, i_hprot, i_hmaster, i_hwdata, i_htrans[0]};

    // A new address phase may only be taken when the current data phase ends.
    always_comb begin
        phase_done = 1'b0;
        case (state_q)
            IDLE, ERR2: phase_done = 1'b1;
            READ:       phase_done = i_ready;
            default:    phase_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ERR1) begin
            state_d = ERR2;
        end else if (phase_done) begin
            if (!accept)  state_d = IDLE;
            else if (bad) state_d = ERR1;
            else          state_d = READ;
        end
    end

    always_ff @(posedge i_hclk or negedge i_hnreset) begin
        if (!i_hnreset) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (phase_done && accept) begin
                addr_q <= i_haddr[31:2];
            end
        end
    end

    always_comb begin
        o_hreadyout = 1'b1;
        o_hresp     = HRESP_OKAY;
        o_hrdata    = '0;
        o_sel       = 1'b0;
        case (state_q)
            READ: begin
                o_sel       = 1'b1;
                o_hreadyout = i_ready;
                if (i_ready) o_hrdata = i_rdata;
            end
            ERR1: begin
                o_hreadyout = 1'b0;
                o_hresp     = HRESP_ERROR;
            end
            ERR2: begin
                o_hresp = HRESP_ERROR;
            end
            default: ;
        endcase
    end

    assign o_addr = addr_q;

endmodule

// File: tb/tb_cache_ahb_ctrl_in.sv
// Scoreboard bench: a master task queues expected data phases, a monitor
// compares every bus cycle against the head of the queue.
module tb_cache_ahb_ctrl_in;
    import cache_pkg::*;

    logic        hclk = 1'b0;
    logic        hnreset;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [3:0]  hmaster;
    logic [1:0]  htrans;
    logic        hready;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        sel;
    logic [29:0] addr;
    logic [31:0] core_rdata;
    logic        core_ready;

    typedef struct {
        bit          err;
        logic [29:0] waddr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ready_pct = 100;
    bit   err_first = 1'b1;
    int   waits = 0;

    always #5 hclk = ~hclk;

    // Single-slave bus: HREADY is this responder's HREADYOUT.
    assign hready = hreadyout;

    cache_ahb_ctrl_in dut (
        .i_hclk      (hclk),
        .i_hnreset   (hnreset),
        .i_hsel      (hsel),
        .i_haddr     (haddr),
        .i_hwrite    (hwrite),
        .i_hsize     (hsize),
        .i_hburst    (hburst),
        .i_hprot     (hprot),
        .i_hmaster   (hmaster),
        .i_htrans    (htrans),
        .i_hready    (hready),
        .i_hwdata    (hwdata),
        .o_hreadyout (hreadyout),
        .o_hresp     (hresp),
        .o_hrdata    (hrdata),
        .o_sel       (sel),
        .o_addr      (addr),
        .i_rdata     (core_rdata),
        .i_ready     (core_ready)
    );

    function automatic logic [31:0] core_data(input logic [29:0] w);
        return ({2'b00, w} * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    // Drive one address phase, hold it until accepted, then record what the
    // following data phase must look like.
    task automatic issue(input logic s, input logic [1:0] t, input logic [31:0] a,
                         input logic wr, input logic [2:0] sz, input int cancel_mode);
        int guard;
        guard   = 0;
        hsel    = s;
        htrans  = t;
        haddr   = a;
        hwrite  = wr;
        hsize   = sz;
        hburst  = 3'($urandom);
        hprot   = 4'($urandom);
        hmaster = 4'($urandom);
        hwdata  = $urandom;
        @(negedge hclk);
        while (!hready && guard <= 50) begin
            if (hresp && htrans[1] &&
                (cancel_mode == 1 || (cancel_mode == 2 && $urandom_range(1, 0) == 1))) begin
                htrans = HTRANS_IDLE;
            end
            guard++;
            @(negedge hclk);
        end
        if (guard > 50) begin
            checks++;
            failures++;
            $display("FAIL addr_phase_timeout: hready stuck low, expected high at %0t", $time);
            bus_idle();
            return;
        end
        @(posedge hclk);
        if (hsel && htrans[1] && hnreset) begin
            exp_q.push_back('{err: (hwrite || hsize != HSIZE_WORD || haddr[1:0] != 2'b00),
                              waddr: haddr[31:2]});
        end
        #1;
    endtask

    // Core model: random ready, data derived from the requested word address.
    initial begin
        core_ready = 1'b0;
        core_rdata = '0;
        forever begin
            @(posedge hclk);
            #1;
            core_ready = (int'($urandom_range(99, 0)) < ready_pct);
            core_rdata = core_ready ? core_data(addr) : $urandom;
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge hclk);
            if (!hnreset) begin
                err_first = 1'b1;
                waits     = 0;
            end else if (exp_q.size() == 0) begin
                check("idle_phase", {29'd0, hreadyout, hresp, sel, hrdata},
                      {29'd0, 1'b1, HRESP_OKAY, 1'b0, 32'd0});
            end else if (exp_q[0].err) begin
                if (err_first) begin
                    check("err_cycle1", {29'd0, hreadyout, hresp, sel, hrdata},
                          {29'd0, 1'b0, HRESP_ERROR, 1'b0, 32'd0});
                    err_first = 1'b0;
                end else begin
                    check("err_cycle2", {29'd0, hreadyout, hresp, sel, hrdata},
                          {29'd0, 1'b1, HRESP_ERROR, 1'b0, 32'd0});
                    exp_q.delete(0);
                    err_first = 1'b1;
                end
            end else begin
                check("core_req", {33'd0, sel, addr}, {33'd0, 1'b1, exp_q[0].waddr});
                if (core_ready) begin
                    check("read_data", {29'd0, hreadyout, hresp, sel, hrdata},
                          {29'd0, 1'b1, HRESP_OKAY, 1'b1, core_data(exp_q[0].waddr)});
                    exp_q.delete(0);
                    waits = 0;
                end else begin
                    check("read_wait", {29'd0, hreadyout, hresp, sel, hrdata},
                          {29'd0, 1'b0, HRESP_OKAY, 1'b1, 32'd0});
                    waits++;
                    if (waits > 20) begin
                        checks++;
                        failures++;
                        $display("FAIL read_timeout: %0d wait cycles, expected at most 20", waits);
                        exp_q.delete(0);
                        waits = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        hnreset = 1'b0;
        hsel    = 1'b0;
        htrans  = HTRANS_IDLE;
        haddr   = '0;
        hwrite  = 1'b0;
        hsize   = HSIZE_WORD;
        hburst  = '0;
        hprot   = '0;
        hmaster = '0;
        hwdata  = '0;
        #3;
        check("reset_outputs", {29'd0, hreadyout, hresp, sel, hrdata},
              {29'd0, 1'b1, HRESP_OKAY, 1'b0, 32'd0});
        check("reset_addr", {34'd0, addr}, 64'd0);
        @(posedge hclk);
        #3 hnreset = 1'b1;
        @(posedge hclk);
        #1;

        // Single read, back-to-back reads, then a slower core
        issue(1'b1, HTRANS_NONSEQ, 32'h0000_1004, 1'b0, HSIZE_WORD, 0);
        issue(1'b1, HTRANS_NONSEQ, 32'h0000_0100, 1'b0, HSIZE_WORD, 0);
        issue(1'b1, HTRANS_SEQ,    32'h0000_0104, 1'b0, HSIZE_WORD, 0);
        issue(1'b1, HTRANS_SEQ,    32'h0000_0108, 1'b0, HSIZE_WORD, 0);
        ready_pct = 30;
        issue(1'b1, HTRANS_NONSEQ, 32'h0000_4440, 1'b0, HSIZE_WORD, 0);
        issue(1'b1, HTRANS_BUSY,   32'h0000_4444, 1'b0, HSIZE_WORD, 0);
        ready_pct = 100;

        // Unsupported transfers
        issue(1'b1, HTRANS_NONSEQ, 32'h0000_0200, 1'b1, HSIZE_WORD, 0);
        issue(1'b1, HTRANS_NONSEQ, 32'h0000_0204, 1'b0, 3'h1, 0);
        issue(1'b1, HTRANS_NONSEQ, 32'h0000_0102, 1'b0, HSIZE_WORD, 0);

        // Pipelined read cancelled in ERR1, then re-driven into ERR2
        issue(1'b1, HTRANS_NONSEQ, 32'h0000_0300, 1'b1, HSIZE_WORD, 0);
        issue(1'b1, HTRANS_NONSEQ, 32'h0000_0304, 1'b0, HSIZE_WORD, 1);
        issue(1'b1, HTRANS_NONSEQ, 32'h0000_0300, 1'b1, HSIZE_WORD, 0);
        issue(1'b1, HTRANS_NONSEQ, 32'h0000_0304, 1'b0, HSIZE_WORD, 0);
        bus_idle();
        repeat (2) @(posedge hclk);
        #1;

        // Randomized traffic
        ready_pct = 60;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [1:0]  t;
            logic [2:0]  sz;
            a = $urandom;
            if ($urandom_range(7, 0) != 0) a[1:0] = 2'b00;
            t  = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 0))
                                              : (($urandom_range(1, 0) == 1) ? HTRANS_SEQ
                                                                             : HTRANS_NONSEQ);
            sz = ($urandom_range(7, 0) == 0) ? 3'($urandom_range(7, 0)) : HSIZE_WORD;
            issue($urandom_range(9, 0) != 0, t, a, $urandom_range(7, 0) == 0, sz, 2);
        end
        bus_idle();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge hclk);
        @(negedge hclk);
        check("drain", 64'(exp_q.size()), 64'd0);

        // Reset asserted while a read waits on the core
        @(posedge hclk);
        #1 ready_pct = 0;
        @(posedge hclk);
        #1;
        issue(1'b1, HTRANS_NONSEQ, 32'h0000_2000, 1'b0, HSIZE_WORD, 0);
        bus_idle();
        @(negedge hclk);
        @(posedge hclk);
        #3 hnreset = 1'b0;
        #1;
        check("reset_mid_read", {29'd0, hreadyout, hresp, sel, hrdata},
              {29'd0, 1'b1, HRESP_OKAY, 1'b0, 32'd0});
        check("reset_mid_addr", {34'd0, addr}, 64'd0);
        exp_q.delete();
        ready_pct = 100;
        @(posedge hclk);
        @(posedge hclk);
        #3 hnreset = 1'b1;
        @(posedge hclk);
        #1;
        issue(1'b1, HTRANS_NONSEQ, 32'h0000_2008, 1'b0, HSIZE_WORD, 0);
        bus_idle();
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check("post_reset_drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
